// File: rtl/reset_pkg.sv
// Shared definitions for the reset sequencer: state encoding and counter sizing helpers.
package reset_pkg;

    typedef enum logic [1:0] {
        ASSERT = 2'd0,
        ESPERA = 2'd1,
        GAP    = 2'd2,
        LISTO  = 2'd3
    } estado_t;

    // One counter is shared by every state, so it must hold the largest terminal count.
    function automatic int unsigned ancho_contador(input int unsigned a,
                                                   input int unsigned b,
                                                   input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    function automatic int unsigned ancho_indice(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/contador_ciclos.sv
// Up-counter with synchronous clear and a terminal-count flag against a runtime limit.
module contador_ciclos #(
    parameter int unsigned ANCHO = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_limpiar,
    input  logic             i_habilitar,
    input  logic [ANCHO-1:0] i_limite,
    output logic             o_fin
);

    logic [ANCHO-1:0] r_cuenta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cuenta <= '0;
        end else if (i_limpiar) begin
            r_cuenta <= '0;
        end else if (i_habilitar) begin
            r_cuenta <= r_cuenta + 1'b1;
        end
    end

    assign o_fin = (r_cuenta == i_limite);

endmodule

// File: rtl/secuenciador_reset.sv
// Holds all downstream stages in reset, then releases them one by one, waiting for each
// stage's acknowledge (with timeout) before releasing the next.
module secuenciador_reset
    import reset_pkg::*;
#(
    parameter int unsigned N_ETAPAS       = 3,
    parameter int unsigned CICLOS_HOLD    = 4,
    parameter int unsigned CICLOS_GAP     = 2,
    parameter int unsigned CICLOS_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pulso_reset,
    input  logic [N_ETAPAS-1:0] listo,
    output logic [N_ETAPAS-1:0] rst_etapa,
    output logic                sistema_listo,
    output logic [N_ETAPAS-1:0] error_timeout
);

    localparam int unsigned ANCHO_CNT = ancho_contador(CICLOS_HOLD, CICLOS_GAP, CICLOS_TIMEOUT);
    localparam int unsigned ANCHO_IDX = ancho_indice(N_ETAPAS);

    // Terminal counts are one less than the cycle count since the counter starts at 0
    // on the edge that enters the state.
    localparam logic [ANCHO_CNT-1:0] LIM_HOLD    = ANCHO_CNT'(CICLOS_HOLD - 1);
    localparam logic [ANCHO_CNT-1:0] LIM_GAP     = ANCHO_CNT'(CICLOS_GAP - 1);
    localparam logic [ANCHO_CNT-1:0] LIM_TIMEOUT = ANCHO_CNT'(CICLOS_TIMEOUT - 1);
    localparam logic [ANCHO_IDX-1:0] IDX_ULTIMO  = ANCHO_IDX'(N_ETAPAS - 1);

    estado_t               r_estado;
    logic [ANCHO_IDX-1:0]  r_idx;
    logic [N_ETAPAS-1:0]   r_rst_etapa;
    logic                  r_sistema_listo;
    logic [N_ETAPAS-1:0]   r_error_timeout;

    logic                  w_fin;
    logic                  w_limpiar;
    logic                  w_habilitar;
    logic [ANCHO_CNT-1:0]  w_limite;
    logic                  w_listo_sel;
    logic [ANCHO_IDX-1:0]  w_idx_sig;

    assign w_listo_sel = listo[r_idx];
    assign w_idx_sig   = r_idx + 1'b1;

    always_comb begin
        w_limite    = '0;
        w_limpiar   = 1'b0;
        w_habilitar = 1'b0;
        case (r_estado)
            ASSERT: begin
                w_limite    = LIM_HOLD;
                w_habilitar = 1'b1;
                w_limpiar   = w_fin;
            end
            ESPERA: begin
                w_limite    = LIM_TIMEOUT;
                w_habilitar = 1'b1;
                w_limpiar   = w_listo_sel | w_fin;
            end
            GAP: begin
                w_limite    = LIM_GAP;
                w_habilitar = 1'b1;
                w_limpiar   = w_fin;
            end
            default: begin
                w_limpiar = 1'b1;
            end
        endcase
        if (pulso_reset) begin
            w_limpiar = 1'b1;
        end
    end

    contador_ciclos #(
        .ANCHO (ANCHO_CNT)
    ) u_contador (
        .clk         (clk),
        .reset       (reset),
        .i_limpiar   (w_limpiar),
        .i_habilitar (w_habilitar),
        .i_limite    (w_limite),
        .o_fin       (w_fin)
    );

    always_ff @(posedge clk) begin
        if (!reset || pulso_reset) begin
            r_estado        <= ASSERT;
            r_idx           <= '0;
            r_rst_etapa     <= '1;
            r_sistema_listo <= 1'b0;
            r_error_timeout <= '0;
        end else begin
            case (r_estado)
                ASSERT: begin
                    r_rst_etapa <= '1;
                    if (w_fin) begin
                        r_rst_etapa[0] <= 1'b0;
                        r_idx          <= '0;
                        r_estado       <= ESPERA;
                    end
                end
                ESPERA: begin
                    // An acknowledge on the timeout edge itself wins over the timeout.
                    if (w_listo_sel) begin
                        r_estado <= GAP;
                    end else if (w_fin) begin
                        r_error_timeout[r_idx] <= 1'b1;
                        r_estado               <= GAP;
                    end
                end
                GAP: begin
                    if (w_fin) begin
                        if (r_idx < IDX_ULTIMO) begin
                            r_idx                  <= w_idx_sig;
                            r_rst_etapa[w_idx_sig] <= 1'b0;
                            r_estado               <= ESPERA;
                        end else begin
                            r_sistema_listo <= 1'b1;
                            r_estado        <= LISTO;
                        end
                    end
                end
                LISTO: begin
                    r_rst_etapa     <= '0;
                    r_sistema_listo <= 1'b1;
                end
                default: begin
                    r_estado <= ASSERT;
                end
            endcase
        end
    end

    assign rst_etapa     = r_rst_etapa;
    assign sistema_listo = r_sistema_listo;
    assign error_timeout = r_error_timeout;

endmodule

// File: tb/tb_secuenciador_reset.sv
// Directed bench for secuenciador_reset with default parameters; edge 0 is the first
// edge that samples reset high.
module tb_secuenciador_reset;

    logic       clk;
    logic       reset;
    logic       pulso_reset;
    logic [2:0] listo;
    logic [2:0] rst_etapa;
    logic       sistema_listo;
    logic [2:0] error_timeout;

    int n_checks;
    int n_errors;
    int e;

    secuenciador_reset #(
        .N_ETAPAS       (3),
        .CICLOS_HOLD    (4),
        .CICLOS_GAP     (2),
        .CICLOS_TIMEOUT (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pulso_reset   (pulso_reset),
        .listo         (listo),
        .rst_etapa     (rst_etapa),
        .sistema_listo (sistema_listo),
        .error_timeout (error_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", tag, e, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic check_out(input string tag, input logic [2:0] r, input logic s,
                             input logic [2:0] er);
        chk({tag, ".rst_etapa"}, {29'd0, rst_etapa}, {29'd0, r});
        chk({tag, ".sistema_listo"}, {31'd0, sistema_listo}, {31'd0, s});
        chk({tag, ".error_timeout"}, {29'd0, error_timeout}, {29'd0, er});
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        pulso_reset = 1'b0;
        step();
        step();
        check_out("reset", 3'b111, 1'b0, 3'b000);
        reset = 1'b1;
        e     = -1;
    endtask

    // Steps up to edge 'last', checking against hand-computed release edges f0..f2,
    // ready edge fl and error edge; optionally changes listo right after edge chg.
    task automatic run_seq(input string tag, input logic [2:0] l0,
                           input int f0, input int f1, input int f2, input int fl,
                           input int ferr, input logic [2:0] verr,
                           input int chg, input logic [2:0] lchg, input int last);
        logic [2:0] r;
        listo = l0;
        while (e < last) begin
            step();
            r = {e < f2, e < f1, e < f0};
            check_out(tag, r, e >= fl, (e >= ferr) ? verr : 3'b000);
            if (e == chg) listo = lchg;
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        e           = 0;
        reset       = 1'b0;
        pulso_reset = 1'b0;
        listo       = 3'b000;

        // 1: all stages acknowledge at once
        do_reset();
        run_seq("t1", 3'b111, 3, 6, 9, 12, 99, 3'b000, -5, 3'b000, 13);

        // 2: stage 1 never acknowledges
        do_reset();
        run_seq("t2", 3'b101, 3, 6, 16, 19, 14, 3'b010, -5, 3'b000, 20);

        // 5: pulso_reset held 10 cycles from LISTO, then release 4 edges after it drops
        pulso_reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_out("t5.hold", 3'b111, 1'b0, 3'b000);
        end
        pulso_reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check_out("t5.rel", (k < 4) ? 3'b111 : 3'b110, 1'b0, 3'b000);
        end

        // 3: stage 1 acknowledges exactly on the timeout edge
        do_reset();
        run_seq("t3", 3'b101, 3, 6, 16, 19, 99, 3'b000, 13, 3'b111, 20);

        // 4: one-cycle pulso_reset sampled at edge 7
        do_reset();
        run_seq("t4.pre", 3'b111, 3, 6, 9, 12, 99, 3'b000, -5, 3'b000, 6);
        pulso_reset = 1'b1;
        step();
        check_out("t4.pulse", 3'b111, 1'b0, 3'b000);
        pulso_reset = 1'b0;
        while (e < 11) begin
            step();
            check_out("t4.post", (e < 11) ? 3'b111 : 3'b110, 1'b0, 3'b000);
        end

        // 6: reset low during stage 1 wait, with pulso_reset also high
        do_reset();
        run_seq("t6.pre", 3'b000, 3, 13, 99, 99, 11, 3'b001, -5, 3'b000, 14);
        reset       = 1'b0;
        pulso_reset = 1'b1;
        listo       = 3'b111;
        step();
        check_out("t6.rst", 3'b111, 1'b0, 3'b000);
        step();
        check_out("t6.rst2", 3'b111, 1'b0, 3'b000);
        reset       = 1'b1;
        pulso_reset = 1'b0;
        e           = -1;
        run_seq("t6.post", 3'b111, 3, 6, 9, 12, 99, 3'b000, -5, 3'b000, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/secuenciador_reset.md
Name: secuenciador_reset

Overview:
Consumes the conditioned, synchronised reset-request pulse produced by the front-panel reset conditioner and generates the held, per-block reset outputs for the rest of the design. All downstream blocks are held in reset for a fixed time. They are then released one at a time, in index order. Each block acknowledges readiness before the next is released, with a timeout per block. A single "system ready" flag goes high when the whole sequence completes.

Parameters:
N_ETAPAS, 3, number of downstream blocks (stages) with their own reset output; legal range 1..16
CICLOS_HOLD, 4, cycles all stage resets stay asserted before the first release; must be >= 1
CICLOS_GAP, 2, cycles between one stage's acknowledge/timeout and the next release; must be >= 1
CICLOS_TIMEOUT, 8, maximum cycles to wait for a stage's listo before moving on; must be >= 1

Ports:
clk  input  1  system clock; everything is on posedge
reset  input  1  synchronous, active-low power-on reset (low = reset)
pulso_reset  input  1  active-high reset-request pulse from the reset conditioner, already synchronous to clk; any width accepted
listo  input  N_ETAPAS  per-stage ready acknowledge; bit i is valid only while stage i is being released
rst_etapa  output  N_ETAPAS  per-stage active-high reset, registered
sistema_listo  output  1  high once every stage has been released, registered
error_timeout  output  N_ETAPAS  sticky per-stage timeout flags, registered

Behaviour:
- Reset priority: reset low dominates everything, including pulso_reset.
- Values while reset is low: rst_etapa = all 1s, sistema_listo = 0, error_timeout = 0, state = ASSERT, all counters = 0, idx = 0.
- States: ASSERT, ESPERA, GAP, LISTO. Encoding is in the package.
- ASSERT:
  - rst_etapa stays all 1s; cnt increments each edge.
  - At the edge where cnt == CICLOS_HOLD-1: clear rst_etapa[0], set idx = 0, clear cnt, go to ESPERA.
  - Timing: if reset is first sampled high at edge 0, rst_etapa[0] falls at edge CICLOS_HOLD-1.
- ESPERA (entered at edge e):
  - Samples listo[idx] on edges e+1 onward; listo at edge e itself is ignored.
  - listo[idx] = 1 at a sampled edge: go to GAP, clear cnt.
  - If edge e+CICLOS_TIMEOUT is reached with no listo: set error_timeout[idx] and go to GAP.
  - listo high at edge e+CICLOS_TIMEOUT counts as acknowledged; no error is raised.
  - listo bits other than idx are ignored.
- GAP:
  - Counts CICLOS_GAP edges. At edge (GAP entry + CICLOS_GAP):
    - if idx < N_ETAPAS-1: increment idx, clear rst_etapa[idx+1], go to ESPERA;
    - otherwise: set sistema_listo = 1, go to LISTO.
- LISTO: all rst_etapa = 0, sistema_listo = 1. Holds until pulso_reset or reset.
- pulso_reset = 1 in any state (mid-sequence included), at the next edge:
  - rst_etapa = all 1s, sistema_listo = 0, error_timeout cleared, cnt = 0, idx = 0, state = ASSERT.
  - A pulso_reset held high keeps re-entering ASSERT with cnt = 0, so the hold window stretches until the pulse drops.
- Monotonic release: released stages stay released until the next ASSERT. Never more than one rst_etapa bit changes 1→0 per edge.
- Counters are $clog2 of max(CICLOS_HOLD, CICLOS_GAP, CICLOS_TIMEOUT)+1 bits wide and saturate-free (always cleared on state change). idx is $clog2(N_ETAPAS) bits, minimum 1.
- All outputs come straight from flops; no combinational path from any input to any output.

Decomposition:
- Shared package reset_pkg: state encoding constants (ASSERT, ESPERA, GAP, LISTO) and a width function for the counter.
- One natural sub-module, contador_ciclos: a parameterised up-counter with synchronous clear and terminal-count flag, instantiated once and shared across states.

Test Plan:
1. Defaults, listo tied to all 1s, reset released at edge 0:
   - rst_etapa[0] falls at edge 3, [1] at edge 6, [2] at edge 9;
   - sistema_listo rises at edge 12; error_timeout = 0.
2. listo[1] held 0, other bits 1:
   - rst_etapa[1] falls at edge 6; error_timeout = 3'b010 at edge 14;
   - rst_etapa[2] falls at edge 16; sistema_listo rises at edge 19.
3. listo[1] rises exactly at edge 14 (the timeout edge):
   - no error; rst_etapa[2] falls at edge 16.
4. One-cycle pulso_reset at edge 7, mid-sequence:
   - at edge 8: rst_etapa = 3'b111, sistema_listo = 0, errors cleared;
   - rst_etapa[0] falls again at edge 11.
5. pulso_reset held high for 10 cycles from LISTO:
   - rst_etapa stays 3'b111 throughout;
   - rst_etapa[0] falls 4 edges after the pulse drops.
6. reset driven low in ESPERA with pulso_reset simultaneously high:
   - outputs take their reset values at that edge;
   - the sequence restarts only once reset returns high.
